// File: rtl/div_pkg.sv
// Shared types and constants for the round-robin divider scheduler.
package div_pkg;

  localparam int unsigned DIV_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  typedef logic req_id_t;

endpackage : div_pkg

// File: rtl/div_rr_scheduler_if.sv
// Two request channels and one tagged response channel of the divider scheduler.
interface div_rr_scheduler_if
  import div_pkg::*;
#(
  parameter int unsigned N = DIV_W
) ();

  logic         req0_valid;
  logic         req0_ready;
  logic [N-1:0] req0_dividend;
  logic [N-1:0] req0_divisor;

  logic         req1_valid;
  logic         req1_ready;
  logic [N-1:0] req1_dividend;
  logic [N-1:0] req1_divisor;

  logic         resp_valid;
  logic         resp_ready;
  req_id_t      resp_id;
  logic [N-1:0] resp_quotient;
  logic [N-1:0] resp_remainder;
  logic         resp_dbz;

  modport slave (
    input  req0_valid, req0_dividend, req0_divisor,
    input  req1_valid, req1_dividend, req1_divisor,
    input  resp_ready,
    output req0_ready, req1_ready,
    output resp_valid, resp_id, resp_quotient, resp_remainder, resp_dbz
  );

  modport master (
    output req0_valid, req0_dividend, req0_divisor,
    output req1_valid, req1_dividend, req1_divisor,
    output resp_ready,
    input  req0_ready, req1_ready,
    input  resp_valid, resp_id, resp_quotient, resp_remainder, resp_dbz
  );

endinterface : div_rr_scheduler_if

// File: rtl/div_restoring_core.sv
// Iterative unsigned restoring divider: one shift/subtract step per cycle, N steps.
// done/quotient/remainder are combinational and describe the state after the
// step taken on the coming edge, so the owner can capture the final result on
// the same edge the last step retires.
module div_restoring_core
  import div_pkg::*;
#(
  parameter int unsigned N = DIV_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [N-1:0] dividend,
  input  logic [N-1:0] divisor,
  output logic         done,
  output logic [N-1:0] quotient,
  output logic [N-1:0] remainder
);

  localparam int unsigned CNT_W = $clog2(N);

  // Partial remainder is kept at N bits: after every step it is below the
  // divisor, so the (N+1)-th bit only exists transiently inside the step.
  logic [N-1:0]     rem_q, rem_d;
  logic [N-1:0]     dvd_q, dvd_d;
  logic [N-1:0]     dvs_q, dvs_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             busy_q, busy_d;

  logic [N:0]       shifted;
  logic [N:0]       trial;
  logic [N-1:0]     step_rem;
  logic [N-1:0]     step_dvd;

  // One restoring step: shift, trial-subtract, keep or restore.
  always_comb begin
    shifted  = {rem_q, dvd_q[N-1]};
    trial    = shifted - {1'b0, dvs_q};
    step_rem = trial[N] ? shifted[N-1:0] : trial[N-1:0];
    step_dvd = {dvd_q[N-2:0], ~trial[N]};
  end

  // Load operands or advance one step and count down.
  always_comb begin
    rem_d  = rem_q;
    dvd_d  = dvd_q;
    dvs_d  = dvs_q;
    cnt_d  = cnt_q;
    busy_d = busy_q;
    if (load) begin
      rem_d  = '0;
      dvd_d  = dividend;
      dvs_d  = divisor;
      cnt_d  = CNT_W'(N - 1);
      busy_d = 1'b1;
    end else if (busy_q) begin
      rem_d = step_rem;
      dvd_d = step_dvd;
      if (cnt_q == '0) begin
        busy_d = 1'b0;
      end else begin
        cnt_d = cnt_q - CNT_W'(1);
      end
    end
  end

  // Datapath state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rem_q  <= '0;
      dvd_q  <= '0;
      dvs_q  <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
    end else begin
      rem_q  <= rem_d;
      dvd_q  <= dvd_d;
      dvs_q  <= dvs_d;
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
    end
  end

  assign done      = busy_q && (cnt_q == '0);
  assign quotient  = step_dvd;
  assign remainder = step_rem;

endmodule : div_restoring_core

// File: rtl/div_rr_scheduler.sv
// Round-robin arbiter and sequencer sharing one restoring divider between two
// requesters, with a held, backpressured response channel.
module div_rr_scheduler
  import div_pkg::*;
#(
  parameter int unsigned N = DIV_W
) (
  input  logic              clk,
  input  logic              rst,
  div_rr_scheduler_if.slave bus
);

  state_e       state_q, state_d;
  req_id_t      last_grant_q, last_grant_d;
  req_id_t      id_q, id_d;
  logic         resp_valid_q, resp_valid_d;
  req_id_t      resp_id_q, resp_id_d;
  logic [N-1:0] resp_quo_q, resp_quo_d;
  logic [N-1:0] resp_rem_q, resp_rem_d;
  logic         resp_dbz_q, resp_dbz_d;

  logic         any_valid;
  logic         both_valid;
  req_id_t      gnt_id;
  logic [N-1:0] sel_dividend;
  logic [N-1:0] sel_divisor;
  logic         req0_ready_c;
  logic         req1_ready_c;

  logic         core_load;
  logic         core_done;
  logic [N-1:0] core_quo;
  logic [N-1:0] core_rem;

  // Grant: a lone requester wins; on a tie the one not granted last wins.
  always_comb begin
    any_valid    = bus.req0_valid | bus.req1_valid;
    both_valid   = bus.req0_valid & bus.req1_valid;
    gnt_id       = both_valid ? req_id_t'(~last_grant_q) : req_id_t'(bus.req1_valid);
    sel_dividend = gnt_id ? bus.req1_dividend : bus.req0_dividend;
    sel_divisor  = gnt_id ? bus.req1_divisor  : bus.req0_divisor;
  end

  // FSM next state, accept handshake and response capture.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    id_d         = id_q;
    resp_valid_d = resp_valid_q;
    resp_id_d    = resp_id_q;
    resp_quo_d   = resp_quo_q;
    resp_rem_d   = resp_rem_q;
    resp_dbz_d   = resp_dbz_q;
    core_load    = 1'b0;
    req0_ready_c = 1'b0;
    req1_ready_c = 1'b0;

    unique case (state_q)
      IDLE: begin
        req0_ready_c = any_valid & (gnt_id == 1'b0);
        req1_ready_c = any_valid & (gnt_id == 1'b1);
        if (any_valid) begin
          last_grant_d = gnt_id;
          id_d         = gnt_id;
          if (sel_divisor == '0) begin
            // Divide by zero bypasses the engine entirely.
            state_d      = DONE;
            resp_valid_d = 1'b1;
            resp_id_d    = gnt_id;
            resp_quo_d   = '1;
            resp_rem_d   = sel_dividend;
            resp_dbz_d   = 1'b1;
          end else begin
            state_d   = BUSY;
            core_load = 1'b1;
          end
        end
      end
      BUSY: begin
        if (core_done) begin
          state_d      = DONE;
          resp_valid_d = 1'b1;
          resp_id_d    = id_q;
          resp_quo_d   = core_quo;
          resp_rem_d   = core_rem;
          resp_dbz_d   = 1'b0;
        end
      end
      DONE: begin
        if (bus.resp_ready) begin
          state_d      = IDLE;
          resp_valid_d = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and response holding registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      id_q         <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_id_q    <= 1'b0;
      resp_quo_q   <= '0;
      resp_rem_q   <= '0;
      resp_dbz_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      id_q         <= id_d;
      resp_valid_q <= resp_valid_d;
      resp_id_q    <= resp_id_d;
      resp_quo_q   <= resp_quo_d;
      resp_rem_q   <= resp_rem_d;
      resp_dbz_q   <= resp_dbz_d;
    end
  end

  div_restoring_core #(
    .N (N)
  ) u_core (
    .clk       (clk),
    .rst       (rst),
    .load      (core_load),
    .dividend  (sel_dividend),
    .divisor   (sel_divisor),
    .done      (core_done),
    .quotient  (core_quo),
    .remainder (core_rem)
  );

  assign bus.req0_ready     = req0_ready_c;
  assign bus.req1_ready     = req1_ready_c;
  assign bus.resp_valid     = resp_valid_q;
  assign bus.resp_id        = resp_id_q;
  assign bus.resp_quotient  = resp_quo_q;
  assign bus.resp_remainder = resp_rem_q;
  assign bus.resp_dbz       = resp_dbz_q;

endmodule : div_rr_scheduler

// File: tb/tb_div_rr_scheduler.sv
// Bench for div_rr_scheduler: vector table, scoreboard and corner sequences.
module tb_div_rr_scheduler;
  import div_pkg::*;

  localparam int unsigned N   = DIV_W;
  localparam int          TMO = 40;
  localparam int          NV  = 10;

  typedef struct {
    logic         id;
    logic [N-1:0] dd;
    logic [N-1:0] ds;
    logic [N-1:0] q;
    logic [N-1:0] r;
    logic         dbz;
    int           lat;
  } vec_t;

  typedef struct {
    logic         id;
    logic [N-1:0] q;
    logic [N-1:0] r;
    logic         dbz;
  } exp_t;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_err;
  int   cyc;
  exp_t sb_q[$];
  vec_t vecs[NV];

  div_rr_scheduler_if #(.N(N)) bus ();

  div_rr_scheduler #(.N(N)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    n_cmp++;
    if (act !== exp_v) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp_v, $time);
    end
  endtask

  function automatic exp_t model(input logic id, input logic [N-1:0] dd, input logic [N-1:0] ds);
    exp_t e;
    e.id = id;
    if (ds == '0) begin
      e.q   = '1;
      e.r   = dd;
      e.dbz = 1'b1;
    end else begin
      e.q   = dd / ds;
      e.r   = dd % ds;
      e.dbz = 1'b0;
    end
    return e;
  endfunction

  function automatic vec_t mkv(input int id, input int dd, input int ds, input int q,
                               input int r, input int dbz, input int lat);
    vec_t v;
    v.id  = 1'(id);
    v.dd  = N'(dd);
    v.ds  = N'(ds);
    v.q   = N'(q);
    v.r   = N'(r);
    v.dbz = 1'(dbz);
    v.lat = lat;
    return v;
  endfunction

  function automatic logic rdy(input logic id);
    return id ? bus.req1_ready : bus.req0_ready;
  endfunction

  // Scoreboard: push on accept, pop and compare on response handshake.
  always @(negedge clk) begin : mon
    exp_t e;
    if (rst) begin
      sb_q.delete();
    end else begin
      chk("ready_exclusive", 32'(bus.req0_ready & bus.req1_ready), 0);
      chk("ready_vs_resp", 32'((bus.req0_ready | bus.req1_ready) & bus.resp_valid), 0);
      if (bus.req0_valid && bus.req0_ready)
        sb_q.push_back(model(1'b0, bus.req0_dividend, bus.req0_divisor));
      if (bus.req1_valid && bus.req1_ready)
        sb_q.push_back(model(1'b1, bus.req1_dividend, bus.req1_divisor));
      if (bus.resp_valid && bus.resp_ready) begin
        if (sb_q.size() == 0) begin
          chk("sb_unexpected_resp", 1, 0);
        end else begin
          e = sb_q.pop_front();
          chk("sb_id", 32'(bus.resp_id), 32'(e.id));
          chk("sb_quotient", 32'(bus.resp_quotient), 32'(e.q));
          chk("sb_remainder", 32'(bus.resp_remainder), 32'(e.r));
          chk("sb_dbz", 32'(bus.resp_dbz), 32'(e.dbz));
        end
      end
    end
  end

  task automatic drive(input logic id, input logic v, input logic [N-1:0] dd, input logic [N-1:0] ds);
    if (id) begin
      bus.req1_valid    = v;
      bus.req1_dividend = dd;
      bus.req1_divisor  = ds;
    end else begin
      bus.req0_valid    = v;
      bus.req0_dividend = dd;
      bus.req0_divisor  = ds;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive(1'b0, 1'b0, '0, '0);
    drive(1'b1, 1'b0, '0, '0);
    bus.resp_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // Present a request, wait for the accept edge, then scramble operands.
  task automatic issue(input logic id, input logic [N-1:0] dd, input logic [N-1:0] ds, output int acc);
    bit got;
    got = 1'b0;
    acc = -1;
    drive(id, 1'b1, dd, ds);
    #1;
    for (int t = 0; t < TMO; t++) begin
      if (rdy(id)) begin
        got = 1'b1;
        break;
      end
      @(posedge clk);
      #2;
    end
    chk("accept_seen", 32'(got), 1);
    if (got) acc = cyc;
    @(posedge clk);
    #1;
    if (got) chk("ready_pulse", 32'(rdy(id)), 0);
    drive(id, 1'b0, ~dd, ~ds);
  endtask

  task automatic wait_resp(output bit got);
    got = 1'b0;
    for (int t = 0; t < TMO; t++) begin
      if (bus.resp_valid) begin
        got = 1'b1;
        break;
      end
      @(posedge clk);
      #1;
    end
    chk("resp_seen", 32'(got), 1);
  endtask

  task automatic run_vec(input int k, input vec_t v);
    int acc;
    bit got;
    issue(v.id, v.dd, v.ds, acc);
    wait_resp(got);
    if (got && acc >= 0) begin
      chk($sformatf("vec%0d_latency", k), 32'(cyc - acc), 32'(v.lat));
      chk($sformatf("vec%0d_id", k), 32'(bus.resp_id), 32'(v.id));
      chk($sformatf("vec%0d_q", k), 32'(bus.resp_quotient), 32'(v.q));
      chk($sformatf("vec%0d_r", k), 32'(bus.resp_remainder), 32'(v.r));
      chk($sformatf("vec%0d_dbz", k), 32'(bus.resp_dbz), 32'(v.dbz));
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, expected finish within 200000 time units");
    $fatal(1);
  end

  initial begin
    int  acc;
    bit  got;
    int  n_acc;
    int  gid[4];
    int  acyc[4];

    vecs[0] = mkv(0, 10,  2,  5, 0, 0, N + 1);
    vecs[1] = mkv(1, 15,  4,  3, 3, 0, N + 1);
    vecs[2] = mkv(1,  3,  7,  0, 3, 0, N + 1);
    vecs[3] = mkv(0,  7,  0, 15, 7, 1, 1);
    vecs[4] = mkv(0,  0,  3,  0, 0, 0, N + 1);
    vecs[5] = mkv(1, 15,  1, 15, 0, 0, N + 1);
    vecs[6] = mkv(0, 15, 15,  1, 0, 0, N + 1);
    vecs[7] = mkv(1,  0,  0, 15, 0, 1, 1);
    vecs[8] = mkv(0,  1, 15,  0, 1, 0, N + 1);
    vecs[9] = mkv(1, 14,  3,  4, 2, 0, N + 1);

    // Reset values.
    rst = 1'b1;
    drive(1'b0, 1'b0, '0, '0);
    drive(1'b1, 1'b0, '0, '0);
    bus.resp_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_resp_valid", 32'(bus.resp_valid), 0);
    chk("rst_resp_id", 32'(bus.resp_id), 0);
    chk("rst_resp_q", 32'(bus.resp_quotient), 0);
    chk("rst_resp_r", 32'(bus.resp_remainder), 0);
    chk("rst_resp_dbz", 32'(bus.resp_dbz), 0);
    rst = 1'b0;
    #1;
    chk("idle_ready0", 32'(bus.req0_ready), 0);
    chk("idle_ready1", 32'(bus.req1_ready), 0);
    @(posedge clk);
    #1;

    // Table of single-requester operations with resp_ready held high.
    for (int k = 0; k < NV; k++) run_vec(k, vecs[k]);

    // Both requesters valid from reset: req0 first, then strict alternation.
    do_reset();
    bus.resp_ready = 1'b1;
    drive(1'b0, 1'b1, N'(9), N'(2));
    drive(1'b1, 1'b1, N'(14), N'(3));
    n_acc = 0;
    for (int t = 0; t < 80 && n_acc < 4; t++) begin
      #1;
      if (bus.req0_ready) begin
        gid[n_acc]  = 0;
        acyc[n_acc] = cyc;
        n_acc++;
      end else if (bus.req1_ready) begin
        gid[n_acc]  = 1;
        acyc[n_acc] = cyc;
        n_acc++;
      end
      if (bus.resp_valid) begin
        if (bus.resp_id == 1'b0) begin
          chk("tie_req0_q", 32'(bus.resp_quotient), 4);
          chk("tie_req0_r", 32'(bus.resp_remainder), 1);
        end else begin
          chk("tie_req1_q", 32'(bus.resp_quotient), 4);
          chk("tie_req1_r", 32'(bus.resp_remainder), 2);
        end
      end
      @(posedge clk);
      #1;
    end
    drive(1'b0, 1'b0, '0, '0);
    drive(1'b1, 1'b0, '0, '0);
    chk("tie_accepts", 32'(n_acc), 4);
    for (int i = 0; i < 4; i++) begin
      if (i < n_acc) chk($sformatf("tie_grant%0d", i), 32'(gid[i]), 32'(i % 2));
      if (i > 0 && i < n_acc) chk($sformatf("tie_spacing%0d", i), 32'(acyc[i] - acyc[i-1]), N + 2);
    end
    wait_resp(got);
    @(posedge clk);
    #1;

    // Backpressure: result held six cycles, no grants while DONE.
    bus.resp_ready = 1'b0;
    issue(1'b0, N'(13), N'(5), acc);
    wait_resp(got);
    drive(1'b0, 1'b1, N'(5), N'(1));
    drive(1'b1, 1'b1, N'(6), N'(2));
    #1;
    for (int t = 0; t < 6; t++) begin
      chk("bp_valid", 32'(bus.resp_valid), 1);
      chk("bp_id", 32'(bus.resp_id), 0);
      chk("bp_q", 32'(bus.resp_quotient), 2);
      chk("bp_r", 32'(bus.resp_remainder), 3);
      chk("bp_dbz", 32'(bus.resp_dbz), 0);
      chk("bp_ready0", 32'(bus.req0_ready), 0);
      chk("bp_ready1", 32'(bus.req1_ready), 0);
      @(posedge clk);
      #2;
    end
    bus.resp_ready = 1'b1;
    @(posedge clk);
    #2;
    chk("bp_drop_valid", 32'(bus.resp_valid), 0);
    chk("bp_next_ready1", 32'(bus.req1_ready), 1);
    chk("bp_next_ready0", 32'(bus.req0_ready), 0);
    @(posedge clk);
    #1;
    drive(1'b0, 1'b0, '0, '0);
    drive(1'b1, 1'b0, '0, '0);
    wait_resp(got);
    @(posedge clk);
    #1;

    // Reset while BUSY: outputs clear at once, no response, req0 wins the next tie.
    bus.resp_ready = 1'b1;
    issue(1'b0, N'(11), N'(3), acc);
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("abort_busy_valid", 32'(bus.resp_valid), 0);
    chk("abort_busy_id", 32'(bus.resp_id), 0);
    chk("abort_busy_q", 32'(bus.resp_quotient), 0);
    chk("abort_busy_r", 32'(bus.resp_remainder), 0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    for (int t = 0; t < 8; t++) begin
      chk("abort_no_resp", 32'(bus.resp_valid), 0);
      @(posedge clk);
      #1;
    end
    drive(1'b0, 1'b1, N'(12), N'(5));
    drive(1'b1, 1'b1, N'(8), N'(3));
    #1;
    chk("post_rst_ready0", 32'(bus.req0_ready), 1);
    chk("post_rst_ready1", 32'(bus.req1_ready), 0);
    run_vec(100, mkv(0, 12, 5, 2, 2, 0, N + 1));
    run_vec(101, mkv(1, 8, 3, 2, 2, 0, N + 1));

    // Reset while DONE with the result stalled: cleared without a clock edge.
    bus.resp_ready = 1'b0;
    issue(1'b1, N'(9), N'(4), acc);
    wait_resp(got);
    rst = 1'b1;
    #1;
    chk("abort_done_valid", 32'(bus.resp_valid), 0);
    chk("abort_done_id", 32'(bus.resp_id), 0);
    chk("abort_done_q", 32'(bus.resp_quotient), 0);
    chk("abort_done_r", 32'(bus.resp_remainder), 0);
    chk("abort_done_dbz", 32'(bus.resp_dbz), 0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    bus.resp_ready = 1'b1;
    for (int t = 0; t < 4; t++) begin
      chk("abort_done_no_resp", 32'(bus.resp_valid), 0);
      @(posedge clk);
      #1;
    end

    chk("sb_empty", 32'(sb_q.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_div_rr_scheduler
